// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter for the shared instruction/data memory port.
// Master 0 is the CPU memory interface, master 1 the loader/DMA; accesses are watchdog-limited.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_done,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_done,
    output logic          m1_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // Counter holds TIMEOUT-1 at most; TIMEOUT is limited to 2..255.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   last_q, last_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   mem_we_q, mem_we_d;
    logic [AW-1:0]          mem_addr_q, mem_addr_d;
    logic [DW-1:0]          mem_wdata_q, mem_wdata_d;
    logic [1:0][DW-1:0]     rdata_q, rdata_d;
    logic [1:0]             done_q, done_d;
    logic [1:0]             err_q, err_d;

    logic grant_vld, grant_id, wait_expired;

    // A tie goes to whoever was not served last; a lone requester always wins.
    assign grant_vld    = m0_req | m1_req;
    assign grant_id     = (m0_req & m1_req) ? ~last_q : m1_req;
    assign wait_expired = (cnt_q == WAIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (grant_vld) state_d = S_ACCESS;
            S_ACCESS: if (mem_ready || wait_expired) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobe comes straight from the state so a reset drops it without waiting for a clock.
    always_comb begin
        mem_req = (state_q == S_ACCESS);
        busy    = (state_q != S_IDLE);
    end

    always_comb begin
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        done_d      = '0;
        err_d       = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    owner_d     = grant_id;
                    cnt_d       = '0;
                    mem_we_d    = grant_id ? m1_we    : m0_we;
                    mem_addr_d  = grant_id ? m1_addr  : m0_addr;
                    mem_wdata_d = grant_id ? m1_wdata : m0_wdata;
                end
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    if (!mem_we_q) rdata_d[owner_q] = mem_rdata;
                    done_d[owner_q] = 1'b1;
                    mem_we_d        = 1'b0;
                end else if (wait_expired) begin
                    // Aborted reads return zero so stale data is never mistaken for a result.
                    if (!mem_we_q) rdata_d[owner_q] = '0;
                    done_d[owner_q] = 1'b1;
                    err_d[owner_q]  = 1'b1;
                    mem_we_d        = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP:  last_d = owner_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            done_q      <= '0;
            err_q       <= '0;
        end else begin
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign owner     = owner_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign m0_rdata  = rdata_q[0];
    assign m1_rdata  = rdata_q[1];
    assign m0_done   = done_q[0];
    assign m1_done   = done_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: transaction-level round-robin model,
// a variable-latency memory responder, and a monitor that checks each completion.
module tb_mem_port_arbiter;
    localparam int AW = 32, DW = 32, TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          req [2];
    logic          we  [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdata [2];
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic m0_done, m1_done, m0_err, m1_err;
    logic mem_req, mem_we, mem_ready, busy, owner;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .owner(owner)
    );

    int n_checks = 0, n_pass = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    endtask

    typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } txn_t;
    typedef struct {
        bit mst; bit we; logic [31:0] addr; logic [31:0] wdata;
        logic [31:0] rdata; bit err; int len;
    } exp_t;

    txn_t plan0[$], plan1[$];
    exp_t exp_q[$];
    int   lat_q[$];
    bit   last_srv = 1'b1;
    logic [31:0] model_rdata [2];
    int   wait_first [2];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A0F0F);
    endfunction

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return $urandom_range(0, 5);
        if (r == 7) return TO - 1;
        return $urandom_range(TO, TO + 3);
    endfunction

    // Round-robin at transaction level: alternate while both have work, starting with the
    // master not served last; then drain whoever remains.
    task automatic predict(input int fixed_lat);
        int i0 = 0, i1 = 0, lat;
        bit cur;
        txn_t t;
        exp_t e;
        while (i0 < plan0.size() || i1 < plan1.size()) begin
            if (i0 < plan0.size() && i1 < plan1.size()) cur = !last_srv;
            else cur = (i0 < plan0.size()) ? 1'b0 : 1'b1;
            if (cur) begin t = plan1[i1]; i1++; end
            else     begin t = plan0[i0]; i0++; end
            lat = (fixed_lat >= 0) ? fixed_lat : pick_lat();
            lat_q.push_back(lat);
            e.mst = cur; e.we = t.we; e.addr = t.addr; e.wdata = t.wdata;
            e.err = (lat >= TO);
            e.len = e.err ? TO : lat + 1;
            if (t.we)       e.rdata = model_rdata[cur];
            else if (e.err) e.rdata = 32'h0;
            else            e.rdata = mem_val(t.addr);
            model_rdata[cur] = e.rdata;
            exp_q.push_back(e);
            last_srv = cur;
        end
    endtask

    task automatic rand_plan(input int n0, input int n1);
        txn_t t;
        plan0.delete(); plan1.delete();
        for (int i = 0; i < n0 + n1; i++) begin
            t.we = 1'($urandom_range(0, 1));
            t.addr = $urandom & 32'h0000FFFC;
            t.wdata = $urandom;
            if (i < n0) plan0.push_back(t); else plan1.push_back(t);
        end
    endtask

    // Holds req through each transaction and presents the next one right at done.
    task automatic drive(input bit m);
        txn_t q[$];
        int w;
        bit got;
        q = m ? plan1 : plan0;
        foreach (q[i]) begin
            req[m] = 1'b1; we[m] = q[i].we; addr[m] = q[i].addr; wdata[m] = q[i].wdata;
            w = 0; got = 0;
            while (!got && w < 400) begin
                @(negedge clk);
                w++;
                got = m ? m1_done : m0_done;
            end
            if (i == 0) wait_first[m] = w;
            if (!got) begin
                chk("done_wait_bound", 0, 1);
                break;
            end
        end
        req[m] = 1'b0;
    endtask

    task automatic run_ep(input int fixed_lat);
        predict(fixed_lat);
        fork
            drive(1'b0);
            drive(1'b1);
        join
        repeat (2) @(negedge clk);
    endtask

    // Memory responder: ready after the planned number of wait cycles, stray readies when idle.
    int acc = 0, cur_lat = 0;
    always @(negedge clk) begin
        if (reset) begin
            acc = 0; mem_ready = 1'b0;
        end else if (mem_req) begin
            acc++;
            if (acc == 1) cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1000;
            mem_ready = (acc == cur_lat + 1);
            mem_rdata = (mem_ready && !mem_we) ? mem_val(mem_addr) : $urandom;
        end else begin
            acc = 0;
            mem_ready = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
    end

    // Monitor/scoreboard.
    int   macc = 0;
    bit   stable = 1'b1;
    logic rec_we;
    logic [31:0] rec_addr, rec_wdata;
    initial begin
        exp_t e;
        bit m;
        forever begin
            @(negedge clk);
            if (reset) begin
                macc = 0; stable = 1'b1;
            end else begin
                if (mem_req) begin
                    if (macc == 0) begin
                        rec_we = mem_we; rec_addr = mem_addr; rec_wdata = mem_wdata;
                    end else if (mem_we !== rec_we || mem_addr !== rec_addr || mem_wdata !== rec_wdata)
                        stable = 1'b0;
                    macc++;
                end
                if (m0_done || m1_done) begin
                    m = m1_done;
                    chk("single_done", {m0_done, m1_done}, m ? 2'b01 : 2'b10);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_master", m, e.mst);
                        chk("owner", owner, e.mst);
                        chk("err", m ? m1_err : m0_err, e.err);
                        chk("other_err", m ? m0_err : m1_err, 0);
                        chk("rdata", m ? m1_rdata : m0_rdata, e.rdata);
                        chk("access_len", macc, e.len);
                        chk("mem_we", rec_we, e.we);
                        chk("mem_addr", rec_addr, e.addr);
                        if (e.we) chk("mem_wdata", rec_wdata, e.wdata);
                        chk("mem_stable", stable, 1);
                        chk("busy_resp", busy, 1);
                        chk("mem_req_resp", mem_req, 0);
                    end
                    macc = 0; stable = 1'b1;
                end else if (!mem_req) begin
                    macc = 0; stable = 1'b1;
                end
            end
        end
    end

    initial begin
        txn_t t;
        int dones;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        model_rdata[0] = '0; model_rdata[1] = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_done", {m0_done, m1_done, m0_err, m1_err}, 0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Zero-wait read: done lands on the 3rd cycle counting the request cycle.
        plan0.delete(); plan1.delete();
        t.we = 0; t.addr = 32'h40; t.wdata = 0; plan0.push_back(t);
        run_ep(0);
        chk("read_latency", wait_first[0], 2);

        // Write with 4 wait states.
        plan0.delete(); plan1.delete();
        t.we = 1; t.addr = 32'h100; t.wdata = 32'h12345678; plan1.push_back(t);
        run_ep(4);

        // Read that never sees ready.
        plan0.delete(); plan1.delete();
        t.we = 0; t.addr = 32'h80; t.wdata = 0; plan0.push_back(t);
        run_ep(100);

        // Sustained contention, then random mixes.
        rand_plan(4, 4);
        run_ep(-1);
        for (int ep = 0; ep < 25; ep++) begin
            int n0, n1;
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range((n0 == 0) ? 1 : 0, 3);
            rand_plan(n0, n1);
            run_ep(-1);
        end

        // Idle with stray readies: nothing may move.
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (m0_done || m1_done || busy) dones++;
        end
        chk("idle_stray_ready", dones, 0);
        chk("idle_rdata0", m0_rdata, model_rdata[0]);
        chk("idle_rdata1", m1_rdata, model_rdata[1]);

        // Serve m0 so the next tie would favour m1, then reset mid-access.
        plan0.delete(); plan1.delete();
        t.we = 0; t.addr = 32'h300; t.wdata = 0; plan0.push_back(t);
        run_ep(2);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h200;
        lat_q.push_back(100);
        repeat (2) @(negedge clk);
        chk("pre_rst_access", mem_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_mem_req", mem_req, 0);
        chk("rst_async_busy", busy, 0);
        @(negedge clk);
        req[0] = 1'b0;
        reset = 1'b0;
        last_srv = 1'b1;
        model_rdata[0] = '0; model_rdata[1] = '0;
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (m0_done || m1_done) dones++;
        end
        chk("rst_no_done", dones, 0);
        chk("rst_rdata_cleared", m0_rdata, 0);

        rand_plan(1, 1);
        run_ep(-1);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified instruction/data memory of the multicycle CPU between two masters. Master 0 is the CPU memory interface, used for both fetch and load/store. Master 1 is the program loader/DMA. The block runs a 3-state FSM with round-robin arbitration, a variable-latency memory handshake and a per-access timeout watchdog. It sits between the CPU datapath memory mux and the memory model.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 16, max ACCESS cycles without mem_ready before the access is aborted with error; legal range 2..255

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
m0_req  in  1  master 0 access request; held until m0_done
m0_we  in  1  master 0 write enable (1=store, 0=load/fetch)
m0_addr  in  AW  master 0 address
m0_wdata  in  DW  master 0 write data
m0_rdata  out  DW  master 0 read data, registered, valid when m0_done=1
m0_done  out  1  one-cycle completion pulse, master 0
m0_err  out  1  timeout flag, valid with m0_done
m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_done, m1_err  same as m0_*, master 1
mem_req  out  1  memory access strobe, high for whole ACCESS state
mem_we  out  1  memory write enable, registered
mem_addr  out  AW  memory address, registered
mem_wdata  out  DW  memory write data, registered
mem_rdata  in  DW  memory read data, sampled when mem_ready=1
mem_ready  in  1  memory completion, single cycle
busy  out  1  high in ACCESS or RESP
owner  out  1  master owning the port (0/1); valid while busy

Behaviour:
- Reset (async): state=IDLE. Deasserted immediately: mem_req, mem_we, busy, m*_done, m*_err. Set to 0: mem_addr, mem_wdata, m*_rdata, owner, wait counter. last_served=1, so master 0 wins the first tie.
- Reset mid-ACCESS: mem_req drops asynchronously and the transaction is dropped with no done pulse. The memory model must tolerate this.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that master.
  - Both req: grant !last_served.
  - On grant, register owner and latch the owner's we/addr/wdata into mem_*. Clear the wait counter. Go to ACCESS.
- ACCESS:
  - mem_req=1. mem_* outputs are stable for the whole state.
  - mem_ready=1: capture mem_rdata into owner's rdata (reads only; writes leave rdata unchanged). err=0. Go to RESP.
  - Otherwise, increment the wait counter. When the counter reaches TIMEOUT-1 with no ready, go to RESP with err=1. Owner's rdata is set to 0 on a timed-out read.
  - Requester inputs are ignored in ACCESS. Dropping req mid-access does not abort it.
- RESP:
  - owner's done=1 for exactly this cycle; err is valid in this cycle only. Set last_served=owner. Go to IDLE.
  - Requester must deassert req or present a new request on the following cycle. A req still high in IDLE is treated as a new request.
- Latency: req sampled in IDLE at cycle N; ACCESS from N+1; ready at ACCESS cycle k gives done at N+1+k. Minimum 3 cycles from request to done (zero-wait memory); 1 idle cycle between back-to-back grants.
- A master requesting continuously is guaranteed service within one other transaction (round-robin, no starvation).
- mem_ready outside ACCESS is ignored.
- done/err are never asserted to the non-owner.

Test Plan:
- Single read: m0_req, we=0, addr=0x0000_0040, memory ready on first ACCESS cycle with rdata=0xDEAD_BEEF. Required: mem_req high 1 cycle, m0_done on the 3rd cycle after req, m0_rdata=0xDEAD_BEEF, m0_err=0.
- Write with waits: m1 write addr=0x100, wdata=0x1234_5678, ready after 4 wait cycles. Required: mem_we=1 and addr/wdata stable for 5 ACCESS cycles, then m1_done; m1_rdata unchanged.
- Contention: m0 and m1 request together from reset, both held continuously. Required: grants alternate m0, m1, m0, m1; owner toggles; no master is served twice in a row.
- Timeout: TIMEOUT=16, m0 read, mem_ready never asserted. Required: mem_req high exactly 16 cycles, then m0_done=1, m0_err=1, m0_rdata=0, and the FSM returns to IDLE.
- Reset mid-ACCESS: assert reset 2 cycles into a wait-state access. Required: mem_req low in the same cycle (async), no done pulse, next tie goes to m0.
- Spurious ready: pulse mem_ready while IDLE, then a stray ready during RESP. Required: no state change, no done, rdata unchanged.
